gray_decode_sched: RTL and testbench

//  Shares a single 1-stage Gray-to-binary decoder between N_CH channels of Gray-coded counter values.

---
 rtl/gray_decode_sched.sv | 165 ++++++++++++++++
 tb/tb_gray_decode_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decode_sched.sv
// Shared Gray-to-binary decoder: captures per-channel Gray snapshots,
// arbitrates round-robin and streams decoded results with overrun flags.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[N_CH]       one-cycle snapshot strobe per channel
//   gray_in         channel c word at gray_in[c*W +: W]
//   ovr_clr[N_CH]   clears the matching sticky overrun flag
//   out_valid/out_ready/out_ch/out_bin  decoded result stream
//   pending[N_CH]   captured but not yet granted
//   overrun[N_CH]   snapshot overwritten before it was granted
//   busy            FSM not idle or any snapshot pending
module gray_decode_sched #(
    parameter int N_CH = 8,
    parameter int W    = 10,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     req,
    input  logic [N_CH*W-1:0]   gray_in,
    input  logic [N_CH-1:0]     ovr_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [W-1:0]        out_bin,
    output logic [N_CH-1:0]     pending,
    output logic [N_CH-1:0]     overrun,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [W-1:0]     cap [N_CH];
    logic [W-1:0]     stage;
    logic [CH_W-1:0]  stage_ch;
    logic [CH_W-1:0]  rr;

    logic             any_pend;
    logic             grant_en;
    logic             grant;
    logic             load_out;
    logic             drop_valid;
    logic             gnt_found;
    logic [CH_W-1:0]  gnt_idx;
    logic [N_CH-1:0]  gnt_oh;
    logic [N_CH-1:0]  ovr_set;
    int               idx;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign any_pend = |pending;
    assign busy     = (state != S_IDLE) | any_pend;

    // Round-robin: first pending channel after the last one granted.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr) + k) % N_CH;
            if (!gnt_found && pending[CH_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

    assign grant   = grant_en & gnt_found;
    assign gnt_oh  = grant ? (N_CH'(1) << gnt_idx) : '0;
    // A re-capture on the granted channel is not an overrun: the old
    // value leaves through the grant on that very edge.
    assign ovr_set = req & pending & ~gnt_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant_en   = 1'b0;
        load_out   = 1'b0;
        drop_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                grant_en = 1'b1;
                if (any_pend) begin
                    state_nx = S_DEC;
                end
            end
            S_DEC: begin
                load_out = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    grant_en   = 1'b1;
                    drop_valid = 1'b1;
                    state_nx   = any_pend ? S_DEC : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                cap[c] <= '0;
            end
            pending   <= '0;
            overrun   <= '0;
            stage     <= '0;
            stage_ch  <= '0;
            rr        <= CH_W'(N_CH-1);
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_bin   <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (req[c]) begin
                    cap[c]     <= gray_in[c*W +: W];
                    pending[c] <= 1'b1;
                end else if (gnt_oh[c]) begin
                    pending[c] <= 1'b0;
                end
            end
            // Set wins over a same-edge clear.
            overrun <= ovr_set | (overrun & ~ovr_clr);
            if (grant) begin
                stage    <= cap[gnt_idx];
                stage_ch <= gnt_idx;
                rr       <= gnt_idx;
            end
            if (load_out) begin
                out_bin   <= gray2bin(stage);
                out_ch    <= stage_ch;
                out_valid <= 1'b1;
            end else if (drop_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_decode_sched.sv
// Self-checking bench for gray_decode_sched: decode table, directed
// corner-case sequences and randomized traffic against a reference model.
module tb_gray_decode_sched;

    localparam int N_CH = 8;
    localparam int W    = 10;
    localparam int CH_W = $clog2(N_CH);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_CH-1:0]     req = '0;
    logic [N_CH*W-1:0]   gray_in = '0;
    logic [N_CH-1:0]     ovr_clr = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CH_W-1:0]     out_ch;
    logic [W-1:0]        out_bin;
    logic [N_CH-1:0]     pending;
    logic [N_CH-1:0]     overrun;
    logic                busy;

    gray_decode_sched #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gray_in   (gray_in),
        .ovr_clr   (ovr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_bin   (out_bin),
        .pending   (pending),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int hs_cnt = 0;

    // Reference model state
    logic [W-1:0]    m_cap [N_CH];
    logic [N_CH-1:0] m_pend;
    logic [N_CH-1:0] m_ovr;
    int              m_rr;
    int              m_phase;   // 0 waiting, 1 decoding, 2 presenting
    logic [W-1:0]    m_sg;
    int              m_sch;
    logic            m_vld;
    int              m_och;
    logic [W-1:0]    m_obin;

    // Binary is the XOR of all right shifts of the Gray word.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int g;
        logic [W-1:0] gval;
        logic [N_CH-1:0] set;
        if (rst) begin
            m_cap   = '{default: '0};
            m_pend  = '0;
            m_ovr   = '0;
            m_rr    = N_CH-1;
            m_phase = 0;
            m_sg    = '0;
            m_sch   = 0;
            m_vld   = 1'b0;
            m_och   = 0;
            m_obin  = '0;
            return;
        end
        g = -1;
        gval = '0;
        if (m_phase == 0 || (m_phase == 2 && out_ready)) begin
            for (int k = 1; k <= N_CH; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N_CH]) g = (m_rr + k) % N_CH;
            end
        end
        if (g >= 0) gval = m_cap[g];
        set = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (req[c]) begin
                if (m_pend[c] && g != c) set[c] = 1'b1;
                m_cap[c]  = gray_in[c*W +: W];
                m_pend[c] = 1'b1;
            end else if (g == c) begin
                m_pend[c] = 1'b0;
            end
        end
        m_ovr = set | (m_ovr & ~ovr_clr);
        case (m_phase)
            0: if (g >= 0) m_phase = 1;
            1: begin
                m_obin  = g2b(m_sg);
                m_och   = m_sch;
                m_vld   = 1'b1;
                m_phase = 2;
            end
            default: if (out_ready) begin
                m_vld   = 1'b0;
                m_phase = (g >= 0) ? 1 : 0;
            end
        endcase
        if (g >= 0) begin
            m_sg  = gval;
            m_sch = g;
            m_rr  = g;
        end
    endtask

    task automatic model_check();
        chk("m_valid",   32'(out_valid), 32'(m_vld));
        chk("m_pending", 32'(pending),   32'(m_pend));
        chk("m_overrun", 32'(overrun),   32'(m_ovr));
        chk("m_busy",    32'(busy),      32'((m_phase != 0) || (m_pend != 0)));
        if (m_vld) begin
            chk("m_ch",  32'(out_ch),  32'(m_och));
            chk("m_bin", 32'(out_bin), 32'(m_obin));
        end
    endtask

    task automatic tick();
        logic hs_pre;
        hs_pre = out_valid & out_ready;
        @(posedge clk);
        model_edge();
        #1;
        if (hs_pre) hs_cnt++;
        model_check();
        req     = '0;
        ovr_clr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic put(input int ch, input logic [W-1:0] g);
        req[ch] = 1'b1;
        gray_in[ch*W +: W] = g;
    endtask

    typedef struct {
        int           ch;
        logic [W-1:0] gray;
        logic [W-1:0] bin;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [CH_W-1:0] h_ch;
        logic [W-1:0]    h_bin;
        bit              got;

        tbl[0] = '{3, 10'h3FF, 10'h2AA};
        tbl[1] = '{0, 10'h000, 10'h000};
        tbl[2] = '{1, 10'h001, 10'h001};
        tbl[3] = '{2, 10'h003, 10'h002};
        tbl[4] = '{5, 10'h002, 10'h003};
        tbl[5] = '{6, 10'h006, 10'h004};
        tbl[6] = '{7, 10'h200, 10'h3FF};
        tbl[7] = '{4, 10'h300, 10'h200};
        tbl[8] = '{2, 10'h155, 10'h199};

        // Reset state and first-result latency
        do_reset();
        chk("rst_valid",   32'(out_valid), 0);
        chk("rst_pending", 32'(pending),   0);
        chk("rst_overrun", 32'(overrun),   0);
        chk("rst_busy",    32'(busy),      0);
        chk("rst_ch",      32'(out_ch),    0);
        chk("rst_bin",     32'(out_bin),   0);
        out_ready = 1'b1;
        put(3, 10'h3FF);
        tick();
        tick();
        tick();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_ch",    32'(out_ch),    3);
        chk("t1_bin",   32'(out_bin),   32'h2AA);
        tick();
        chk("t1_busy",  32'(busy),      0);

        // Decode table, one channel at a time
        for (int i = 0; i < 9; i++) begin
            out_ready = 1'b1;
            put(tbl[i].ch, tbl[i].gray);
            tick();
            got = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                tick();
                if (out_valid) got = 1'b1;
            end
            if (!got) begin
                nvec++;
                nerr++;
                $display("FAIL tbl_timeout: entry %0d got no out_valid", i);
            end else begin
                chk("tbl_ch",  32'(out_ch),  32'(tbl[i].ch));
                chk("tbl_bin", 32'(out_bin), 32'(tbl[i].bin));
            end
            tick();
        end

        // Same-edge requests: served in channel order, 2 cycles apart
        do_reset();
        out_ready = 1'b1;
        put(0, 10'd1);
        put(2, 10'd3);
        put(5, 10'd2);
        tick();
        tick();
        tick();
        chk("t2_ch0", 32'(out_ch), 0);
        chk("t2_b0",  32'(out_bin), 1);
        tick();
        chk("t2_gap", 32'(out_valid), 0);
        tick();
        chk("t2_ch2", 32'(out_ch), 2);
        chk("t2_b2",  32'(out_bin), 2);
        tick();
        tick();
        chk("t2_ch5", 32'(out_ch), 5);
        chk("t2_b5",  32'(out_bin), 3);
        tick();

        // Backpressure hold
        do_reset();
        out_ready = 1'b0;
        put(6, 10'd5);
        tick();
        tick();
        tick();
        h_ch  = out_ch;
        h_bin = out_bin;
        chk("t3_valid", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_v",   32'(out_valid), 1);
            chk("t3_hold_ch",  32'(out_ch),    32'(h_ch));
            chk("t3_hold_bin", 32'(out_bin),   32'(h_bin));
        end
        hs_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_handshakes", hs_cnt, 1);

        // Overrun and set-beats-clear
        do_reset();
        out_ready = 1'b0;
        put(0, 10'd0);
        tick();
        tick();
        tick();
        put(1, 10'd5);
        tick();
        put(1, 10'd6);
        tick();
        chk("t4_ovr", 32'(overrun[1]), 1);
        put(1, 10'd6);
        ovr_clr[1] = 1'b1;
        tick();
        chk("t4_set_wins", 32'(overrun[1]), 1);
        ovr_clr[1] = 1'b1;
        tick();
        chk("t4_clr", 32'(overrun[1]), 0);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t4_ch",  32'(out_ch),  1);
        chk("t4_bin", 32'(out_bin), 4);
        tick();

        // Re-capture on the granting edge
        do_reset();
        out_ready = 1'b1;
        put(4, 10'd3);
        tick();
        put(4, 10'd6);
        tick();
        chk("t5_pend", 32'(pending[4]), 1);
        chk("t5_ovr",  32'(overrun[4]), 0);
        tick();
        chk("t5_ch_a",  32'(out_ch),  4);
        chk("t5_bin_a", 32'(out_bin), 2);
        tick();
        tick();
        chk("t5_ch_b",  32'(out_ch),  4);
        chk("t5_bin_b", 32'(out_bin), 4);
        tick();

        // Reset mid-operation
        do_reset();
        out_ready = 1'b0;
        put(0, 10'd9);
        tick();
        tick();
        tick();
        put(1, 10'd1);
        put(2, 10'd2);
        put(3, 10'd3);
        tick();
        put(1, 10'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_pend",  32'(pending),   0);
        chk("t6_ovr",   32'(overrun),   0);
        put(7, 10'h3FF);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_ch",  32'(out_ch),  7);
        chk("t6_bin", 32'(out_bin), 32'h2AA);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                req[c] = ($urandom_range(0, 6) == 0);
                ovr_clr[c] = ($urandom_range(0, 15) == 0);
                gray_in[c*W +: W] = W'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
